alu_result_fifo: RTL
====================

// Module: alu_result_fifo
// PURPOSE
//   Downstream buffer for the 4-bit ALU. Captures each ALU result together with its
//   carryout, parity and zero flags into a small FIFO. Hands entries to the consumer
//   (writeback or display) over a valid/ready handshake. Decouples ALU issue rate from
//   consumer stalls and reports dropped results.
// PARAMETERS
//   DATA_W   4   ALU result width (bits)
//   DEPTH    4   FIFO entries; power of two, >= 2
//   AW       2   pointer width = log2(DEPTH); derived, not overridden
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous, active-high reset
//   in_valid     in   1        ALU entry presented this cycle
//   in_ready     out  1        FIFO can accept (not full)
//   in_result    in   DATA_W   ALU result
//   in_carryout  in   1        ALU carry out
//   in_parity    in   1        ALU parity flag
//   in_zero      in   1        ALU zero flag
//   out_valid    out  1        head entry available
//   out_ready    in   1        consumer accepts head entry
//   out_result   out  DATA_W   head result
//   out_carryout out  1        head carry
//   out_parity   out  1        head parity
//   out_zero     out  1        head zero
//   count        out  AW+1     entries held, 0..DEPTH
//   overflow     out  1        sticky: an entry was offered while full
// BEHAVIOUR
//   - Storage: DEPTH x (DATA_W+3) words {result,carry,parity,zero}; write ptr wp and
//     read ptr rp of AW bits wrap modulo DEPTH; count register of AW+1 bits.
//   - push = in_valid & in_ready; pop = out_valid & out_ready; both sampled on clk rise.
//   - in_ready = (count != DEPTH); comb from count only, with no full-bypass: a push
//     while full is refused even if pop is asserted in the same cycle.
//   - out_valid = (count != 0). out_* = mem[rp] (comb read of registered storage).
//     out_* are don't-care when out_valid=0 but must not be X after reset.
//   - Latency: a push into an empty FIFO appears as out_valid=1 on the next cycle.
//   - Push only: mem[wp]<=data, wp++, count++. Pop only: rp++, count--.
//     Push and pop together: both pointers advance, count unchanged.
//   - Pop while empty is ignored: no pointer move, no underflow.
//   - overflow <= 1 when in_valid & ~in_ready. It stays set until rst.
//   - Ordering is strict FIFO; flags always travel with their own result.
//   - rst (async, any time incl. mid-transfer): wp=rp=0, count=0, overflow=0,
//     out_valid=0, in_ready=1, memory cleared to 0. In-flight data is discarded.
// CONFIGURATION
//   ALU_FIFO_STATS_EN defined: adds outputs zero_cnt[7:0] and carry_cnt[7:0].
//     - Each counts popped entries with zero=1 / carryout=1 respectively.
//     - Counters saturate at 8'hFF and reset to 0 on rst.
//   Not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//   1 rst pulse mid-stream with count=3 -> count=0, out_valid=0, in_ready=1, overflow=0
//     immediately (async).
//   2 push {B,c0,p1,z0}, out_ready=0 -> next cycle out_valid=1, out_result=4'hB, count=1.
//   3 push 4 entries 1,2,3,4 with no pop -> in_ready=0, count=4. 5th push of 5 ->
//     overflow=1, entry dropped. Popping then yields 1,2,3,4 in order.
//   4 with count=2, push and pop in the same cycle -> count stays 2 and order is preserved.
//     Run 10 cycles to cover pointer wrap.
//   5 full FIFO with in_valid=1 and out_ready=1 in the same cycle -> pop happens, push
//     refused, count=3, overflow=1.
//   6 (ALU_FIFO_STATS_EN) pop 3 entries with zero=1 and 1 with carry=1 -> zero_cnt=3,
//     carry_cnt=1. 300 zero pops -> zero_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: small FIFO that buffers ALU results together with their
// carry/parity/zero flags and hands them to a consumer over valid/ready.
// A push while full is refused (no full-bypass) and latches a sticky overflow flag.
// Optional feature macro: ALU_FIFO_STATS_EN adds saturating zero_cnt/carry_cnt
// counters of popped entries with zero=1 / carryout=1.
module alu_result_fifo #(
   parameter int  DATA_W = 4,
   parameter int  DEPTH  = 4,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_carryout,
   input  logic              in_parity,
   input  logic              in_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_carryout,
   output logic              out_parity,
   output logic              out_zero,
   output logic [AW:0]       count,
   output logic              overflow
`ifdef ALU_FIFO_STATS_EN
   ,
   output logic [7:0]        zero_cnt,
   output logic [7:0]        carry_cnt
`endif
);

   localparam int          EW       = DATA_W + 3;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   // Storage word layout: {result, carry, parity, zero}
   function automatic logic [EW-1:0] pack_entry(input logic [DATA_W-1:0] res,
                                                input logic              cy,
                                                input logic              par,
                                                input logic              zf);
      return {res, cy, par, zf};
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          push_s, pop_s;
   logic          in_ready_s, out_valid_s;
   logic [EW-1:0] head_s;
   logic [EW-1:0] wdata_s;

   // Handshake qualification: readiness depends on the registered count only
   always_comb begin
      in_ready_s  = (count_q != FULL_CNT);
      out_valid_s = (count_q != {(AW+1){1'b0}});
      push_s      = in_valid & in_ready_s;
      pop_s       = out_valid_s & out_ready;
      wdata_s     = pack_entry(in_result, in_carryout, in_parity, in_zero);
      head_s      = mem_q[rp_q];
   end

   // Next-state for pointers, occupancy and sticky overflow
   always_comb begin
      wp_d       = wp_q;
      rp_d       = rp_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push_s) begin
         wp_d = wp_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         wp_d = wp_q;
      end
      if (pop_s) begin
         rp_d = rp_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
         rp_d = rp_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
         2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
         default: count_d = count_q;
      endcase
      if (in_valid && !in_ready_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Control state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q       <= {AW{1'b0}};
         rp_q       <= {AW{1'b0}};
         count_q    <= {(AW+1){1'b0}};
         overflow_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage: cleared on reset so the head never reads as X
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {EW{1'b0}};
         end
      end else if (push_s) begin
         mem_q[wp_q] <= wdata_s;
      end
   end

   assign in_ready     = in_ready_s;
   assign out_valid    = out_valid_s;
   assign out_result   = head_s[EW-1:3];
   assign out_carryout = head_s[2];
   assign out_parity   = head_s[1];
   assign out_zero     = head_s[0];
   assign count        = count_q;
   assign overflow     = overflow_q;

`ifdef ALU_FIFO_STATS_EN
   logic [7:0] zero_cnt_q, zero_cnt_d;
   logic [7:0] carry_cnt_q, carry_cnt_d;

   // Statistics next-state: count popped entries carrying each flag, saturating
   always_comb begin
      zero_cnt_d  = zero_cnt_q;
      carry_cnt_d = carry_cnt_q;
      if (pop_s && head_s[0]) begin
         zero_cnt_d = sat_inc8(zero_cnt_q);
      end else begin
         zero_cnt_d = zero_cnt_q;
      end
      if (pop_s && head_s[2]) begin
         carry_cnt_d = sat_inc8(carry_cnt_q);
      end else begin
         carry_cnt_d = carry_cnt_q;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_cnt_q  <= 8'd0;
         carry_cnt_q <= 8'd0;
      end else begin
         zero_cnt_q  <= zero_cnt_d;
         carry_cnt_q <= carry_cnt_d;
      end
   end

   assign zero_cnt  = zero_cnt_q;
   assign carry_cnt = carry_cnt_q;
`endif

endmodule
